// File: rtl/apb_pkg.sv
// Shared APB definitions: requester state encoding and default bus widths.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait timer: flags the wait cycle that uses up the LIMIT budget.
// Instantiated by apb_requester only when APB_REQUESTER_TIMEOUT_EN is defined.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic presetn,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  // Down-counter holding the wait cycles left before the terminal cycle.
  localparam logic [15:0] LOAD = 16'(LIMIT - 1);

  logic [15:0] remaining;

  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) begin
      remaining <= LOAD;
    end else if (clear) begin
      remaining <= LOAD;
    end else if (tick && (remaining != 16'd0)) begin
      remaining <= remaining - 16'd1;
    end
  end

  assign expired = tick && (remaining == 16'd0);

endmodule

// File: rtl/apb_requester.sv
// APB initiator: one command in, one SETUP/ACCESS transfer out, one response back.
// Optional ACCESS timeout is compiled in with APB_REQUESTER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | psel high, penable low, exactly one cycle
// ACCESS | psel and penable high until pready (or timeout)
module apb_requester
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = APB_ADDR_W,
  parameter int unsigned DATA_WIDTH     = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  presetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SETUP  = SETUP;
  localparam logic [1:0] S_ACCESS = ACCESS;

  logic [1:0] state;
  logic       tmo_expired;

`ifdef APB_REQUESTER_TIMEOUT_EN
  logic timer_clear;
  logic timer_tick;

  assign timer_clear = (state == S_SETUP);
  assign timer_tick  = (state == S_ACCESS) && !pready;

  apb_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (clk),
    .presetn (presetn),
    .clear   (timer_clear),
    .tick    (timer_tick),
    .expired (tmo_expired)
  );
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign tmo_expired        = 1'b0;
`endif

  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= S_SETUP;
            cmd_ready <= 1'b0;
            psel      <= 1'b1;
            pwrite    <= cmd_write;
            paddr     <= cmd_addr;
            pwdata    <= cmd_wdata;
          end
        end
        S_SETUP: begin
          state   <= S_ACCESS;
          penable <= 1'b1;
        end
        S_ACCESS: begin
          // pready takes priority over a timeout landing in the same cycle.
          if (pready) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr;
            rsp_rdata <= (pslverr || pwrite) ? '0 : prdata;
          end else if (tmo_expired) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          psel      <= 1'b0;
          penable   <= 1'b0;
        end
      endcase
    end
  end

endmodule
